// File: rtl/cat_board_ctrl.sv
// ---------------------------------------------------------------------------
// cat_board_ctrl : button-driven game logic for the 8x8 trap-the-cat board
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cat_board_ctrl #(
  parameter int          CAT_START_ROW = 3,
  parameter int          CAT_START_COL = 3,
  parameter logic [63:0] INIT_BLOCKS   = 64'h0,
  parameter int          RESULT_HOLD   = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  output logic [63:0] blocked,
  output logic [2:0]  cat_row,
  output logic [2:0]  cat_col,
  output logic [2:0]  cur_row,
  output logic [2:0]  cur_col,
  output logic [4:0]  state,
  output logic [7:0]  move_count
);

  typedef enum logic [4:0] {
    S_START   = 5'b00001,
    S_PLAY    = 5'b00010,
    S_OVER    = 5'b00100,
    S_WIN     = 5'b01000,
    S_CATMOVE = 5'b10000
  } state_t;

  localparam logic [2:0]  CAT_R0  = 3'(CAT_START_ROW);
  localparam logic [2:0]  CAT_C0  = 3'(CAT_START_COL);
  localparam logic [5:0]  CAT_IDX = {CAT_R0, CAT_C0};
  localparam logic [63:0] BLOCKS0 = INIT_BLOCKS & ~(64'd1 << CAT_IDX);
  localparam int          HW      = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESULT_HOLD - 1);

  state_t        st, st_nx;
  logic [63:0]   blocked_nx;
  logic [2:0]    cat_row_nx, cat_col_nx, cur_row_nx, cur_col_nx;
  logic [7:0]    move_count_nx;
  logic [HW-1:0] hold, hold_nx;

  logic [2:0] nb_r [4];
  logic [2:0] nb_c [4];
  logic       found;
  logic [2:0] best_r, best_c, best_d;
  logic [5:0] cur_idx;

  function automatic logic [2:0] edge_dist(input logic [2:0] r, input logic [2:0] c);
    logic [2:0] m;
    m = r;
    if (3'd7 - r < m) m = 3'd7 - r;
    if (c < m)        m = c;
    if (3'd7 - c < m) m = 3'd7 - c;
    return m;
  endfunction

  assign state   = st;
  assign cur_idx = {cur_row, cur_col};

  // Neighbour order up, down, left, right doubles as the tie-break order.
  always_comb begin
    nb_r[0] = cat_row - 3'd1;  nb_c[0] = cat_col;
    nb_r[1] = cat_row + 3'd1;  nb_c[1] = cat_col;
    nb_r[2] = cat_row;         nb_c[2] = cat_col - 3'd1;
    nb_r[3] = cat_row;         nb_c[3] = cat_col + 3'd1;
  end

  always_comb begin
    found  = 1'b0;
    best_r = cat_row;
    best_c = cat_col;
    best_d = 3'd7;
    for (int i = 0; i < 4; i++) begin
      if (!blocked[{nb_r[i], nb_c[i]}] &&
          (!found || edge_dist(nb_r[i], nb_c[i]) < best_d)) begin
        found  = 1'b1;
        best_r = nb_r[i];
        best_c = nb_c[i];
        best_d = edge_dist(nb_r[i], nb_c[i]);
      end
    end
  end

  always_comb begin
    st_nx         = st;
    blocked_nx    = blocked;
    cat_row_nx    = cat_row;
    cat_col_nx    = cat_col;
    cur_row_nx    = cur_row;
    cur_col_nx    = cur_col;
    move_count_nx = move_count;
    hold_nx       = hold;
    case (st)
      S_START: begin
        if (btn_center) begin
          st_nx         = S_PLAY;
          blocked_nx    = BLOCKS0;
          cat_row_nx    = CAT_R0;
          cat_col_nx    = CAT_C0;
          cur_row_nx    = 3'd0;
          cur_col_nx    = 3'd0;
          move_count_nx = 8'd0;
        end
      end
      S_PLAY: begin
        if (btn_center) begin
          if (!blocked[cur_idx] && cur_idx != {cat_row, cat_col}) begin
            blocked_nx[cur_idx] = 1'b1;
            if (move_count != 8'hFF) move_count_nx = move_count + 8'd1;
            st_nx = S_CATMOVE;
          end
        end else if (btn_up) begin
          cur_row_nx = cur_row - 3'd1;
        end else if (btn_down) begin
          cur_row_nx = cur_row + 3'd1;
        end else if (btn_left) begin
          cur_col_nx = cur_col - 3'd1;
        end else if (btn_right) begin
          cur_col_nx = cur_col + 3'd1;
        end
      end
      S_CATMOVE: begin
        // Edge check first, so neighbour arithmetic never wraps off the board.
        if (edge_dist(cat_row, cat_col) == 3'd0) begin
          st_nx   = S_OVER;
          hold_nx = '0;
        end else if (!found) begin
          st_nx   = S_WIN;
          hold_nx = '0;
        end else begin
          cat_row_nx = best_r;
          cat_col_nx = best_c;
          st_nx      = S_PLAY;
        end
      end
      S_OVER, S_WIN: begin
        if (hold == HOLD_LAST) st_nx = S_START;
        else                   hold_nx = hold + 1'b1;
      end
      default: st_nx = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_START;
      blocked    <= BLOCKS0;
      cat_row    <= CAT_R0;
      cat_col    <= CAT_C0;
      cur_row    <= 3'd0;
      cur_col    <= 3'd0;
      move_count <= 8'd0;
      hold       <= '0;
    end else begin
      st         <= st_nx;
      blocked    <= blocked_nx;
      cat_row    <= cat_row_nx;
      cat_col    <= cat_col_nx;
      cur_row    <= cur_row_nx;
      cur_col    <= cur_col_nx;
      move_count <= move_count_nx;
      hold       <= hold_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cat_board_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cat_board_ctrl : directed scenarios plus randomized play against a model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cat_board_ctrl;

  localparam int          RH     = 4;
  localparam logic [63:0] INIT_B = (64'd1 << 19) | (64'd1 << 26) | (64'd1 << 35);
  localparam logic [4:0]  UP = 5'b00001, DN = 5'b00010, LT = 5'b00100,
                          RT = 5'b01000, CT = 5'b10000, NB = 5'b00000;
  localparam logic [4:0]  ST_START = 5'b00001, ST_PLAY = 5'b00010, ST_OVER = 5'b00100,
                          ST_WIN = 5'b01000, ST_CM = 5'b10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_center = 1'b0;

  logic [63:0] a_blocked, b_blocked;
  logic [2:0]  a_cat_row, a_cat_col, a_cur_row, a_cur_col;
  logic [2:0]  b_cat_row, b_cat_col, b_cur_row, b_cur_col;
  logic [4:0]  a_state, b_state;
  logic [7:0]  a_move_count, b_move_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain game rules on integers.
  int          m_st;  // 0 START, 1 PLAY, 2 GAMEOVER, 3 GAMEWIN, 4 CATMOVE
  logic [63:0] m_blk;
  int          m_cr, m_cc, m_ur, m_uc, m_mc, m_hold;

  cat_board_ctrl #(.CAT_START_ROW(3), .CAT_START_COL(3), .INIT_BLOCKS(64'h0),
                   .RESULT_HOLD(RH)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center), .blocked(a_blocked),
    .cat_row(a_cat_row), .cat_col(a_cat_col), .cur_row(a_cur_row), .cur_col(a_cur_col),
    .state(a_state), .move_count(a_move_count));

  cat_board_ctrl #(.CAT_START_ROW(3), .CAT_START_COL(3), .INIT_BLOCKS(INIT_B),
                   .RESULT_HOLD(RH)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center), .blocked(b_blocked),
    .cat_row(b_cat_row), .cat_col(b_cat_col), .cur_row(b_cur_row), .cur_col(b_cur_col),
    .state(b_state), .move_count(b_move_count));

  always #5 clk = ~clk;

  function automatic logic [88:0] pack(input logic [4:0] s, input logic [63:0] b,
                                       input int cr, input int cc, input int ur,
                                       input int uc, input int mc);
    return {s, b, 3'(cr), 3'(cc), 3'(ur), 3'(uc), 8'(mc)};
  endfunction

  function automatic logic [88:0] snap_a();
    return {a_state, a_blocked, a_cat_row, a_cat_col, a_cur_row, a_cur_col, a_move_count};
  endfunction

  function automatic logic [88:0] snap_b();
    return {b_state, b_blocked, b_cat_row, b_cat_col, b_cur_row, b_cur_col, b_move_count};
  endfunction

  function automatic int mdist(input int r, input int c);
    int m;
    m = r;
    if (7 - r < m) m = 7 - r;
    if (c < m)     m = c;
    if (7 - c < m) m = 7 - c;
    return m;
  endfunction

  task automatic model_reset();
    m_st = 0; m_blk = 64'h0; m_cr = 3; m_cc = 3;
    m_ur = 0; m_uc = 0; m_mc = 0; m_hold = 0;
  endtask

  task automatic model_step(input logic [4:0] b);
    int dr [4] = '{-1, 1, 0, 0};
    int dc [4] = '{0, 0, -1, 1};
    int best, bd, br, bc, r, c;
    case (m_st)
      0: if (b[4]) begin model_reset(); m_st = 1; end
      1: begin
        if (b[4]) begin
          if (!m_blk[m_ur*8+m_uc] && !(m_ur == m_cr && m_uc == m_cc)) begin
            m_blk[m_ur*8+m_uc] = 1'b1;
            if (m_mc < 255) m_mc++;
            m_st = 4;
          end
        end
        else if (b[0]) m_ur = (m_ur + 7) % 8;
        else if (b[1]) m_ur = (m_ur + 1) % 8;
        else if (b[2]) m_uc = (m_uc + 7) % 8;
        else if (b[3]) m_uc = (m_uc + 1) % 8;
      end
      4: begin
        if (mdist(m_cr, m_cc) == 0) begin m_st = 2; m_hold = 0; end
        else begin
          best = -1; bd = 99; br = 0; bc = 0;
          for (int i = 0; i < 4; i++) begin
            r = m_cr + dr[i]; c = m_cc + dc[i];
            if (!m_blk[r*8+c] && mdist(r, c) < bd) begin
              best = i; bd = mdist(r, c); br = r; bc = c;
            end
          end
          if (best < 0) begin m_st = 3; m_hold = 0; end
          else begin m_cr = br; m_cc = bc; m_st = 1; end
        end
      end
      default: begin
        if (m_hold == RH - 1) m_st = 0;
        else m_hold++;
      end
    endcase
  endtask

  // Called at a negedge; applies buttons for exactly one posedge, returns at the next negedge.
  task automatic step(input logic [4:0] b);
    {btn_center, btn_right, btn_left, btn_down, btn_up} = b;
    @(posedge clk);
    model_step(b);
    @(negedge clk);
    {btn_center, btn_right, btn_left, btn_down, btn_up} = NB;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {btn_center, btn_right, btn_left, btn_down, btn_up} = NB;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (snap_a() !== pack(ST_START, 64'h0, 3, 3, 0, 0, 0)) begin
      n_bad++; $display("FAIL reset_a: got %h want %h", snap_a(), pack(ST_START, 64'h0, 3, 3, 0, 0, 0));
    end
    n_cmp++;
    if (b_blocked !== INIT_B) begin
      n_bad++; $display("FAIL reset_b_blocked: got %h want %h", b_blocked, INIT_B);
    end
    step(LT | UP | DN | RT);
    n_cmp++;
    if (snap_a() !== pack(ST_START, 64'h0, 3, 3, 0, 0, 0)) begin
      n_bad++; $display("FAIL start_ignores_dirs: got %h want %h", snap_a(), pack(ST_START, 64'h0, 3, 3, 0, 0, 0));
    end
  endtask

  task automatic test_start();
    step(CT);
    n_cmp++;
    if (snap_a() !== pack(ST_PLAY, 64'h0, 3, 3, 0, 0, 0)) begin
      n_bad++; $display("FAIL start_to_play: got %h want %h", snap_a(), pack(ST_PLAY, 64'h0, 3, 3, 0, 0, 0));
    end
  endtask

  task automatic test_cursor();
    logic [4:0] seq [5] = '{LT, UP, UP | RT, DN, DN};
    int         er  [5] = '{0, 7, 6, 7, 0};
    for (int i = 0; i < 5; i++) begin
      step(seq[i]);
      n_cmp++;
      if ({a_cur_row, a_cur_col} !== {3'(er[i]), 3'd7}) begin
        n_bad++; $display("FAIL cursor_%0d: got (%0d,%0d) want (%0d,7)", i, a_cur_row, a_cur_col, er[i]);
      end
    end
  endtask

  task automatic test_place();
    step(DN); step(DN); step(RT); step(RT); step(RT); step(RT);
    n_cmp++;
    if ({a_cur_row, a_cur_col} !== {3'd2, 3'd3}) begin
      n_bad++; $display("FAIL cursor_to_2_3: got (%0d,%0d) want (2,3)", a_cur_row, a_cur_col);
    end
    step(CT);
    n_cmp++;
    if (snap_a() !== pack(ST_CM, 64'd1 << 19, 3, 3, 2, 3, 1)) begin
      n_bad++; $display("FAIL place_catmove: got %h want %h", snap_a(), pack(ST_CM, 64'd1 << 19, 3, 3, 2, 3, 1));
    end
    step(CT | LT);
    n_cmp++;
    if (snap_a() !== pack(ST_PLAY, 64'd1 << 19, 3, 2, 2, 3, 1)) begin
      n_bad++; $display("FAIL cat_moves_left: got %h want %h", snap_a(), pack(ST_PLAY, 64'd1 << 19, 3, 2, 2, 3, 1));
    end
  endtask

  task automatic test_ignored();
    step(CT);
    n_cmp++;
    if (snap_a() !== pack(ST_PLAY, 64'd1 << 19, 3, 2, 2, 3, 1)) begin
      n_bad++; $display("FAIL center_on_blocked: got %h want %h", snap_a(), pack(ST_PLAY, 64'd1 << 19, 3, 2, 2, 3, 1));
    end
    step(DN); step(LT);
    step(CT | UP);
    n_cmp++;
    if (snap_a() !== pack(ST_PLAY, 64'd1 << 19, 3, 2, 3, 2, 1)) begin
      n_bad++; $display("FAIL center_on_cat: got %h want %h", snap_a(), pack(ST_PLAY, 64'd1 << 19, 3, 2, 3, 2, 1));
    end
  endtask

  task automatic test_escape();
    logic [63:0] blk;
    int n;
    blk = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 29);
    step(RT); step(CT); step(NB);
    n_cmp++;
    if ({a_cat_row, a_cat_col} !== {3'd3, 3'd1}) begin
      n_bad++; $display("FAIL cat_to_3_1: got (%0d,%0d) want (3,1)", a_cat_row, a_cat_col);
    end
    step(RT); step(CT); step(NB);
    n_cmp++;
    if ({a_cat_row, a_cat_col} !== {3'd3, 3'd0}) begin
      n_bad++; $display("FAIL cat_to_3_0: got (%0d,%0d) want (3,0)", a_cat_row, a_cat_col);
    end
    step(RT); step(CT); step(NB);
    n_cmp++;
    if (a_state !== ST_OVER) begin
      n_bad++; $display("FAIL gameover_entry: got %b want %b", a_state, ST_OVER);
    end
    n = 0;
    while (a_state === ST_OVER && n < 10) begin n++; step(CT | LT); end
    n_cmp++;
    if (n != RH) begin
      n_bad++; $display("FAIL gameover_hold: got %0d cycles want %0d", n, RH);
    end
    n_cmp++;
    if (snap_a() !== pack(ST_START, blk, 3, 0, 3, 5, 4)) begin
      n_bad++; $display("FAIL gameover_frozen: got %h want %h", snap_a(), pack(ST_START, blk, 3, 0, 3, 5, 4));
    end
  endtask

  task automatic test_win();
    int n;
    do_reset();
    step(CT);
    step(DN); step(DN); step(DN);
    step(RT); step(RT); step(RT); step(RT);
    step(CT);
    n_cmp++;
    if (snap_b() !== pack(ST_CM, INIT_B | (64'd1 << 28), 3, 3, 3, 4, 1)) begin
      n_bad++; $display("FAIL win_place: got %h want %h", snap_b(), pack(ST_CM, INIT_B | (64'd1 << 28), 3, 3, 3, 4, 1));
    end
    step(NB);
    n = 0;
    while (b_state === ST_WIN && n < 10) begin n++; step(CT); end
    n_cmp++;
    if (n != RH) begin
      n_bad++; $display("FAIL gamewin_hold: got %0d cycles want %0d", n, RH);
    end
    n_cmp++;
    if (snap_b() !== pack(ST_START, INIT_B | (64'd1 << 28), 3, 3, 3, 4, 1)) begin
      n_bad++; $display("FAIL gamewin_to_start: got %h want %h", snap_b(), pack(ST_START, INIT_B | (64'd1 << 28), 3, 3, 3, 4, 1));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(CT);
    step(CT);
    n_cmp++;
    if (a_state !== ST_CM) begin
      n_bad++; $display("FAIL async_setup: got %b want %b", a_state, ST_CM);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (snap_a() !== pack(ST_START, 64'h0, 3, 3, 0, 0, 0)) begin
      n_bad++; $display("FAIL async_reset: got %h want %h", snap_a(), pack(ST_START, 64'h0, 3, 3, 0, 0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic [4:0] b;
    logic [88:0] exp_v;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      b = {($urandom_range(0, 7) < 2) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15))};
      step(b);
      exp_v = pack(5'(1 << m_st), m_blk, m_cr, m_cc, m_ur, m_uc, m_mc);
      n_cmp++;
      if (snap_a() !== exp_v) begin
        n_bad++; $display("FAIL random_cycle_%0d: got %h want %h", i, snap_a(), exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_cursor();
    test_place();
    test_ignored();
    test_escape();
    test_win();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
